// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- length-aware UART frame assembler.
//
// Collects bytes from a UART low-level receiver into a HEADER_SIZE-bit header
// followed by a payload whose byte count is taken from a header field. The
// completed frame is passed downstream over a valid/ready handshake. An
// assembly register and an output register form a double buffer, so the next
// frame can be received while the previous one waits to be consumed.
// Malformed frames are dropped on inter-byte timeout or over-length.
//
// Optional feature: define UART_FRAME_RX_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of all header and payload bytes). A mismatch drops the
// frame with code 3.
//
// Ports:
//   clk_in          in   clock
//   rst_n_in        in   asynchronous active-low reset
//   ll_valid_in     in   byte available from the UART receiver
//   ll_byte_in      in   received byte
//   ll_ready_out    out  a byte is accepted this cycle when ll_valid_in is high
//   header_out      out  header of the output frame
//   message_out     out  payload of the output frame (unused upper bits 0)
//   length_out      out  payload length in bytes of the output frame
//   bdge_valid_out  out  output frame valid, held until accepted
//   ctrl_ready_in   in   downstream accepts the frame
//   err_out         out  one-cycle pulse when a frame is dropped
//   err_code_out    out  cause of last drop: 1 timeout, 2 over-length, 3 checksum
module uart_frame_rx #(
  parameter int HEADER_SIZE      = 32,
  parameter int MAX_MESSAGE_SIZE = 512,
  parameter int LEN_LSB          = 0,
  parameter int LEN_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES   = 100000
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        ll_valid_in,
  input  logic [7:0]                  ll_byte_in,
  output logic                        ll_ready_out,
  output logic [HEADER_SIZE-1:0]      header_out,
  output logic [MAX_MESSAGE_SIZE-1:0] message_out,
  output logic [LEN_WIDTH-1:0]        length_out,
  output logic                        bdge_valid_out,
  input  logic                        ctrl_ready_in,
  output logic                        err_out,
  output logic [1:0]                  err_code_out
);

  localparam int HDR_BYTES = HEADER_SIZE / 8;
  localparam int MAX_BYTES = MAX_MESSAGE_SIZE / 8;
  localparam int HDR_CW    = $clog2(HDR_BYTES + 1);
  localparam int MAX_CW    = $clog2(MAX_BYTES + 1);
  localparam int CNT_W0    = (LEN_WIDTH > HDR_CW) ? LEN_WIDTH : HDR_CW;
  // One spare bit so byte_cnt + 1 never wraps at the largest length.
  localparam int CNT_W     = ((CNT_W0 > MAX_CW) ? CNT_W0 : MAX_CW) + 1;
  localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] MAX_BYTES_C = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] HDR_LAST_C  = CNT_W'(HDR_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST_C  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK,
    S_COMMIT,
    S_STALL
  } state_t;

  state_t                      state_reg;
  logic [CNT_W-1:0]            byte_cnt_reg;
  logic [TMO_W-1:0]            tmo_cnt_reg;
  logic [LEN_WIDTH-1:0]        len_reg;
  logic [HEADER_SIZE-1:0]      hdr_asm_reg;
  logic [MAX_MESSAGE_SIZE-1:0] msg_asm_reg;
  logic [HEADER_SIZE-1:0]      hdr_out_reg;
  logic [MAX_MESSAGE_SIZE-1:0] msg_out_reg;
  logic [LEN_WIDTH-1:0]        len_out_reg;
  logic                        out_valid_reg;
  logic                        ready_reg;
  logic                        err_reg;
  logic [1:0]                  err_code_reg;
`ifdef UART_FRAME_RX_CHECKSUM_EN
  logic [7:0]                  csum_reg;
`endif

  logic                        accept;
  logic                        hdr_last;
  logic                        pay_last;
  logic                        overlen;
  logic [HEADER_SIZE-1:0]      hdr_new;
  logic [LEN_WIDTH-1:0]        len_new;
  logic [HDR_BYTES-1:0]        hdr_sel;
  logic [MAX_BYTES-1:0]        msg_sel;

  assign accept   = ll_valid_in && ready_reg;
  assign hdr_last = (byte_cnt_reg == HDR_LAST_C);
  assign pay_last = ((byte_cnt_reg + CNT_W'(1)) == CNT_W'(len_reg));
  assign overlen  = (CNT_W'(len_reg) > MAX_BYTES_C);

  // Byte-lane selects. Payload lanes beyond MAX_BYTES simply do not exist, so
  // an over-length frame stores only its first MAX_BYTES bytes.
  for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr_sel
    assign hdr_sel[gi] = (byte_cnt_reg == CNT_W'(gi));
  end
  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_msg_sel
    assign msg_sel[gi] = (byte_cnt_reg == CNT_W'(gi));
  end

  // Header with the incoming byte merged in. In IDLE the previous frame's
  // header is ignored, which gives the clear-at-frame-start behaviour.
  always_comb begin
    hdr_new = (state_reg == S_IDLE) ? '0 : hdr_asm_reg;
    for (int i = 0; i < HDR_BYTES; i++) begin
      if (hdr_sel[i]) hdr_new[i*8 +: 8] = ll_byte_in;
    end
  end
  assign len_new = hdr_new[LEN_LSB +: LEN_WIDTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg     <= S_IDLE;
      byte_cnt_reg  <= '0;
      tmo_cnt_reg   <= '0;
      len_reg       <= '0;
      hdr_asm_reg   <= '0;
      msg_asm_reg   <= '0;
      hdr_out_reg   <= '0;
      msg_out_reg   <= '0;
      len_out_reg   <= '0;
      out_valid_reg <= 1'b0;
      // Ready comes up on the first clock after reset release.
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'd0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
      csum_reg      <= 8'd0;
`endif
    end else begin
      err_reg <= 1'b0;
      if (state_reg == S_IDLE) ready_reg <= 1'b1;
      // Consumption frees the output register unless a commit refills it below.
      if (out_valid_reg && ctrl_ready_in) out_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE, S_HEADER: begin
          if (accept) begin
            hdr_asm_reg <= hdr_new;
            if (state_reg == S_IDLE) msg_asm_reg <= '0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
            csum_reg <= (state_reg == S_IDLE) ? ll_byte_in : (csum_reg ^ ll_byte_in);
`endif
            if (hdr_last) begin
              len_reg      <= len_new;
              byte_cnt_reg <= '0;
              if (len_new != '0) begin
                state_reg <= S_PAYLOAD;
              end else begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
                state_reg <= S_CHECK;
`else
                state_reg <= S_COMMIT;
                ready_reg <= 1'b0;
`endif
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
              state_reg    <= S_HEADER;
            end
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (msg_sel[i]) msg_asm_reg[i*8 +: 8] <= ll_byte_in;
            end
`ifdef UART_FRAME_RX_CHECKSUM_EN
            csum_reg <= csum_reg ^ ll_byte_in;
`endif
            if (pay_last) begin
              byte_cnt_reg <= '0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
              state_reg <= S_CHECK;
`else
              if (overlen) begin
                state_reg    <= S_IDLE;
                err_reg      <= 1'b1;
                err_code_reg <= 2'd2;
              end else begin
                state_reg <= S_COMMIT;
                ready_reg <= 1'b0;
              end
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end
        end

`ifdef UART_FRAME_RX_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            byte_cnt_reg <= '0;
            // Over-length is reported in preference to a checksum mismatch.
            if (overlen) begin
              state_reg    <= S_IDLE;
              err_reg      <= 1'b1;
              err_code_reg <= 2'd2;
            end else if (ll_byte_in == csum_reg) begin
              state_reg <= S_COMMIT;
              ready_reg <= 1'b0;
            end else begin
              state_reg    <= S_IDLE;
              err_reg      <= 1'b1;
              err_code_reg <= 2'd3;
            end
          end
        end
`endif

        S_COMMIT, S_STALL: begin
          if (!out_valid_reg || ctrl_ready_in) begin
            hdr_out_reg   <= hdr_asm_reg;
            msg_out_reg   <= msg_asm_reg;
            len_out_reg   <= len_reg;
            out_valid_reg <= 1'b1;
            ready_reg     <= 1'b1;
            byte_cnt_reg  <= '0;
            state_reg     <= S_IDLE;
          end else begin
            state_reg <= S_STALL;
          end
        end

        default: begin
          state_reg    <= S_IDLE;
          byte_cnt_reg <= '0;
          ready_reg    <= 1'b1;
        end
      endcase

      // Inter-byte timeout, active only while a frame is partially received.
      // An accepted byte in the same cycle always wins over expiry.
      if ((TIMEOUT_CYCLES != 0) &&
          (state_reg == S_HEADER || state_reg == S_PAYLOAD || state_reg == S_CHECK)) begin
        if (accept) begin
          tmo_cnt_reg <= '0;
        end else if (tmo_cnt_reg == TMO_LAST_C) begin
          tmo_cnt_reg  <= '0;
          byte_cnt_reg <= '0;
          state_reg    <= S_IDLE;
          err_reg      <= 1'b1;
          err_code_reg <= 2'd1;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
      end else begin
        tmo_cnt_reg <= '0;
      end
    end
  end

  assign ll_ready_out   = ready_reg;
  assign header_out     = hdr_out_reg;
  assign message_out    = msg_out_reg;
  assign length_out     = len_out_reg;
  assign bdge_valid_out = out_valid_reg;
  assign err_out        = err_reg;
  assign err_code_out   = err_code_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx (HEADER_SIZE 32, 512-bit payload,
// 8-bit length at header bit 0, timeout shortened to 50 cycles).
module tb_uart_frame_rx;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b1;
  logic         ll_valid_in = 1'b0;
  logic [7:0]   ll_byte_in = 8'd0;
  logic         ll_ready_out;
  logic [31:0]  header_out;
  logic [511:0] message_out;
  logic [7:0]   length_out;
  logic         bdge_valid_out;
  logic         ctrl_ready_in = 1'b1;
  logic         err_out;
  logic [1:0]   err_code_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]   pay [0:127];
  logic [511:0] exp_msg;

  uart_frame_rx #(
    .HEADER_SIZE(32),
    .MAX_MESSAGE_SIZE(512),
    .LEN_LSB(0),
    .LEN_WIDTH(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .ll_valid_in(ll_valid_in),
    .ll_byte_in(ll_byte_in),
    .ll_ready_out(ll_ready_out),
    .header_out(header_out),
    .message_out(message_out),
    .length_out(length_out),
    .bdge_valid_out(bdge_valid_out),
    .ctrl_ready_in(ctrl_ready_in),
    .err_out(err_out),
    .err_code_out(err_code_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one byte and hold it until the DUT takes it. Returns #1 after the
  // accepting edge with ll_valid_in dropped.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    ll_valid_in = 1'b1;
    ll_byte_in  = b;
    while (!ll_ready_out && guard < 300) begin
      tick();
      guard++;
    end
    chk("byte_accept_bound", 512'(guard < 300), 512'(1));
    tick();
    ll_valid_in = 1'b0;
  endtask

  // Header plus n payload bytes from pay[]; appends a correct checksum byte
  // when the checksum feature is built in.
  task automatic send_frame(input logic [31:0] hdr, input int n);
    logic [7:0] cs;
    cs = 8'd0;
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[8*i +: 8]);
      cs = cs ^ hdr[8*i +: 8];
    end
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i]);
      cs = cs ^ pay[i];
    end
`ifdef UART_FRAME_RX_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  // Called in the COMMIT cycle with ctrl_ready_in = 1: frame appears next
  // cycle for exactly one cycle.
  task automatic expect_frame(input string tag, input logic [31:0] h,
                              input logic [511:0] m, input logic [7:0] l);
    chk({tag, "_ready_commit"}, 512'(ll_ready_out), 512'(0));
    chk({tag, "_valid_commit"}, 512'(bdge_valid_out), 512'(0));
    tick();
    chk({tag, "_valid"}, 512'(bdge_valid_out), 512'(1));
    chk({tag, "_header"}, 512'(header_out), 512'(h));
    chk({tag, "_message"}, message_out, m);
    chk({tag, "_length"}, 512'(length_out), 512'(l));
    chk({tag, "_ready_after"}, 512'(ll_ready_out), 512'(1));
    tick();
    chk({tag, "_valid_drop"}, 512'(bdge_valid_out), 512'(0));
  endtask

  initial begin
    // Reset
    #1 rst_n_in = 1'b0;
    #2;
    chk("rst_ready", 512'(ll_ready_out), 512'(0));
    chk("rst_valid", 512'(bdge_valid_out), 512'(0));
    chk("rst_header", 512'(header_out), 512'(0));
    chk("rst_err_code", 512'(err_code_out), 512'(0));
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
    chk("post_rst_ready", 512'(ll_ready_out), 512'(1));
    chk("post_rst_err", 512'(err_out), 512'(0));

    // LEN=4, payload AA BB CC DD
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    send_frame(32'h0000_0004, 4);
    exp_msg = '0; exp_msg[31:0] = 32'hDDCC_BBAA;
    expect_frame("len4", 32'h0000_0004, exp_msg, 8'd4);

    // LEN=0: delivered two cycles after the last header byte, payload cleared
    send_frame(32'h0000_1200, 0);
    expect_frame("len0", 32'h0000_1200, 512'd0, 8'd0);

    // Double buffering: A held while B completes and stalls
    ctrl_ready_in = 1'b0;
    pay[0] = 8'h11; pay[1] = 8'h22;
    send_frame(32'h0000_0002, 2);
    tick();
    chk("a_valid", 512'(bdge_valid_out), 512'(1));
    pay[0] = 8'h33;
    send_frame(32'h8000_0001, 1);
    chk("b_commit_ready", 512'(ll_ready_out), 512'(0));
    tick();
    chk("stall_ready", 512'(ll_ready_out), 512'(0));
    chk("stall_valid", 512'(bdge_valid_out), 512'(1));
    chk("stall_a_header", 512'(header_out), 512'(32'h0000_0002));
    chk("stall_a_message", message_out, 512'h2211);
    chk("stall_a_length", 512'(length_out), 512'(2));
    ctrl_ready_in = 1'b1;
    tick();
    ctrl_ready_in = 1'b0;
    chk("b_valid", 512'(bdge_valid_out), 512'(1));
    chk("b_header", 512'(header_out), 512'(32'h8000_0001));
    chk("b_message", message_out, 512'h33);
    chk("b_length", 512'(length_out), 512'(1));
    chk("b_ready", 512'(ll_ready_out), 512'(1));
    tick();
    chk("b_held", 512'(bdge_valid_out), 512'(1));
    ctrl_ready_in = 1'b1;
    tick();
    chk("b_consumed", 512'(bdge_valid_out), 512'(0));

    // Over-length: LEN=65, all 65 bytes accepted, dropped with code 2
    for (int i = 0; i < 65; i++) pay[i] = 8'(i + 1);
    send_frame(32'h0000_0041, 65);
    chk("ovl_err", 512'(err_out), 512'(1));
    chk("ovl_code", 512'(err_code_out), 512'(2));
    chk("ovl_valid", 512'(bdge_valid_out), 512'(0));
    tick();
    chk("ovl_err_pulse", 512'(err_out), 512'(0));
    chk("ovl_code_held", 512'(err_code_out), 512'(2));
    chk("ovl_no_frame", 512'(bdge_valid_out), 512'(0));
    chk("ovl_ready", 512'(ll_ready_out), 512'(1));
    pay[0] = 8'h5A;
    send_frame(32'h0000_0001, 1);
    expect_frame("after_ovl", 32'h0000_0001, 512'h5A, 8'd1);

    // Timeout after two header bytes
    send_byte(8'h07);
    send_byte(8'h08);
    for (int i = 0; i < 49; i++) tick();
    chk("tmo_before", 512'(err_out), 512'(0));
    tick();
    chk("tmo_err", 512'(err_out), 512'(1));
    chk("tmo_code", 512'(err_code_out), 512'(1));
    tick();
    chk("tmo_err_pulse", 512'(err_out), 512'(0));
    chk("tmo_ready", 512'(ll_ready_out), 512'(1));
    pay[0] = 8'h9C; pay[1] = 8'h7E;
    send_frame(32'h0000_0002, 2);
    expect_frame("after_tmo", 32'h0000_0002, 512'h7E9C, 8'd2);

`ifdef UART_FRAME_RX_CHECKSUM_EN
    // Bad checksum (5A instead of 5B)
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'h5A);
    chk("csum_bad_err", 512'(err_out), 512'(1));
    chk("csum_bad_code", 512'(err_code_out), 512'(3));
    chk("csum_bad_valid", 512'(bdge_valid_out), 512'(0));
    tick();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'h5B);
    expect_frame("csum_good", 32'h0000_0001, 512'h5A, 8'd1);
`endif

    // Reset mid-payload: outputs clear immediately without a clock edge
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hE1); send_byte(8'hE2);
    rst_n_in = 1'b0;
    #2;
    chk("mid_rst_ready", 512'(ll_ready_out), 512'(0));
    chk("mid_rst_header", 512'(header_out), 512'(0));
    chk("mid_rst_message", message_out, 512'd0);
    chk("mid_rst_length", 512'(length_out), 512'(0));
    chk("mid_rst_valid", 512'(bdge_valid_out), 512'(0));
    chk("mid_rst_err", 512'(err_out), 512'(0));
    chk("mid_rst_code", 512'(err_code_out), 512'(0));
    tick();
    rst_n_in = 1'b1;
    tick();
    chk("mid_rst_ready_back", 512'(ll_ready_out), 512'(1));
    pay[0] = 8'h66;
    send_frame(32'h0000_0001, 1);
    expect_frame("after_rst", 32'h0000_0001, 512'h66, 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
